load_unit: RTL and testbench

Parametrised memory-load engine that executes one RISC-V style load instruction at a time.
- Computes the effective address base + sext(imm).
- Issues a read to an external synchronous word-wide RAM with configurable read latency.
- Extracts and sign- or zero-extends the byte, half or word lane.
- Returns the result through a valid/ready response handshake.
- Sits between decode/register-read and the register-file writeback in the mini-core datapath.

---
 rtl/load_pkg.sv | 43 ++++
 rtl/load_align.sv | 28 ++
 rtl/load_unit.sv | 133 +++++++++++++
 tb/tb_load_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/load_pkg.sv
// rtl/load_pkg.sv - shared constants, state encoding and decode helpers for the load unit
package load_pkg;

    localparam int XPRLEN = 32;

    localparam logic [6:0] OPCODE_MEMORY = 7'b0000011;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LD  = 3'b011;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_LWU = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } load_state_e;

    // LD and LWU need a 64-bit datapath, so they are rejected like 111.
    function automatic logic is_illegal(input logic [2:0] funct3);
        logic bad;
        case (funct3)
            FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU: bad = 1'b0;
            default:                                                 bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic mis;
        case (funct3)
            FUNCT3_LH, FUNCT3_LHU: mis = off[0];
            FUNCT3_LW:             mis = (off != 2'b00);
            default:               mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - little-endian lane select and sign/zero extension of a RAM word
module load_align
    import load_pkg::*;
(
    input  logic [XPRLEN-1:0] rdata,
    input  logic [1:0]        off,
    input  logic [2:0]        funct3,
    output logic [XPRLEN-1:0] ext_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{off, 3'b000} +: 8];
        half_lane = rdata[{off[1], 4'b0000} +: 16];
        ext_data  = '0;
        case (funct3)
            FUNCT3_LB:  ext_data = {{(XPRLEN-8){byte_lane[7]}}, byte_lane};
            FUNCT3_LH:  ext_data = {{(XPRLEN-16){half_lane[15]}}, half_lane};
            FUNCT3_LW:  ext_data = rdata;
            FUNCT3_LBU: ext_data = {{(XPRLEN-8){1'b0}}, byte_lane};
            FUNCT3_LHU: ext_data = {{(XPRLEN-16){1'b0}}, half_lane};
            default:    ext_data = '0;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// rtl/load_unit.sv - single-outstanding load engine: address calc, RAM read, lane extract, response
module load_unit
    import load_pkg::*;
#(
    parameter int XPRLEN  = load_pkg::XPRLEN,
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [XPRLEN-1:0]   req_base,
    input  logic [11:0]         req_imm,
    input  logic [2:0]          req_funct3,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XPRLEN-1:0]   rsp_data,
    output logic                rsp_err,
    output logic                mem_rd_en,
    output logic [ADDR_W-3:0]   mem_addr,
    input  logic [XPRLEN-1:0]   mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_READ = 2'(READ);
    localparam logic [1:0] S_WAIT = 2'(WAIT);
    localparam logic [1:0] S_RESP = 2'(RESP);

    localparam int              CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    logic [1:0]        state_q,    state_d;
    logic [ADDR_W-3:0] waddr_q,    waddr_d;
    logic [1:0]        off_q,      off_d;
    logic [2:0]        funct3_q,   funct3_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [XPRLEN-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q,  rsp_err_d;

    logic [XPRLEN-1:0] ea;
    logic [1:0]        req_off;
    logic [ADDR_W-3:0] req_waddr;
    logic              req_bad;
    logic [XPRLEN-1:0] aligned_data;

    assign ea        = req_base + {{(XPRLEN-12){req_imm[11]}}, req_imm};
    assign req_off   = ea[1:0];
    assign req_waddr = ea[ADDR_W-1:2];
    assign req_bad   = is_illegal(req_funct3) || is_misaligned(req_funct3, req_off);

    load_align u_align (
        .rdata    (mem_rdata),
        .off      (off_q),
        .funct3   (funct3_q),
        .ext_data (aligned_data)
    );

    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        off_d      = off_q;
        funct3_d   = funct3_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_bad) begin
                        // The RAM address is left untouched so mem_addr only moves on a real read.
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        waddr_d  = req_waddr;
                        off_d    = req_off;
                        funct3_d = req_funct3;
                        state_d  = S_READ;
                    end
                end
            end
            S_READ: begin
                cnt_d   = CNT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_d = aligned_data;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            waddr_q    <= '0;
            off_q      <= '0;
            funct3_q   <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            waddr_q    <= waddr_d;
            off_q      <= off_d;
            funct3_q   <= funct3_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Gated with rst_n so upstream never sees ready while the unit is held in reset.
    assign req_ready = rst_n && (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign mem_rd_en = (state_q == S_READ);
    assign mem_addr  = waddr_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - directed self-checking bench for load_unit at MEM_LAT=1 and MEM_LAT=3
module tb_load_unit;

    logic        clk;
    logic        rst_n;
    logic        sel3;
    logic        req_valid;
    logic [31:0] req_base;
    logic [11:0] req_imm;
    logic [2:0]  req_funct3;
    logic        rsp_ready;

    logic        req_ready1, rsp_valid1, rsp_err1, mem_rd_en1;
    logic [31:0] rsp_data1, mem_rdata1;
    logic [7:0]  mem_addr1;
    logic        req_ready3, rsp_valid3, rsp_err3, mem_rd_en3;
    logic [31:0] rsp_data3, mem_rdata3;
    logic [7:0]  mem_addr3;

    logic [31:0] mem [0:255];
    logic [31:0] p1  = 32'h0;
    logic [31:0] q3a = 32'h0;
    logic [31:0] q3b = 32'h0;
    logic [31:0] q3c = 32'h0;

    int n_assert = 0;
    int n_fail   = 0;

    load_unit #(.XPRLEN(32), .ADDR_W(10), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid && !sel3), .req_ready(req_ready1),
        .req_base(req_base), .req_imm(req_imm), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data1), .rsp_err(rsp_err1),
        .mem_rd_en(mem_rd_en1), .mem_addr(mem_addr1), .mem_rdata(mem_rdata1)
    );

    load_unit #(.XPRLEN(32), .ADDR_W(10), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid && sel3), .req_ready(req_ready3),
        .req_base(req_base), .req_imm(req_imm), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data3), .rsp_err(rsp_err3),
        .mem_rd_en(mem_rd_en3), .mem_addr(mem_addr3), .mem_rdata(mem_rdata3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: one register stage for the 1-cycle unit, three for the 3-cycle unit.
    always @(posedge clk) begin
        if (mem_rd_en1) p1 <= mem[mem_addr1];
        if (mem_rd_en3) q3a <= mem[mem_addr3];
        q3b <= q3a;
        q3c <= q3b;
    end
    assign mem_rdata1 = p1;
    assign mem_rdata3 = q3c;

    logic        v_req_ready, v_rsp_valid, v_rsp_err, v_rd_en;
    logic [31:0] v_rsp_data;
    logic [7:0]  v_addr;
    assign v_req_ready = sel3 ? req_ready3 : req_ready1;
    assign v_rsp_valid = sel3 ? rsp_valid3 : rsp_valid1;
    assign v_rsp_err   = sel3 ? rsp_err3   : rsp_err1;
    assign v_rd_en     = sel3 ? mem_rd_en3 : mem_rd_en1;
    assign v_rsp_data  = sel3 ? rsp_data3  : rsp_data1;
    assign v_addr      = sel3 ? mem_addr3  : mem_addr1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_load(input logic u3, input logic [31:0] base, input logic [11:0] imm,
                            input logic [2:0] f3, input logic [31:0] exp_data, input logic exp_err,
                            input int exp_lat, input logic [7:0] exp_addr);
        int          n;
        int          rd;
        logic [7:0]  maddr;
        @(negedge clk);
        sel3 = u3;
        #1;
        chk("req_ready_before", {31'b0, v_req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_base   = base;
        req_imm    = imm;
        req_funct3 = f3;
        @(negedge clk);
        req_valid  = 1'b0;
        req_base   = 32'hFFFF_FFFF;
        req_funct3 = 3'b111;
        n     = 1;
        rd    = 0;
        maddr = 8'h00;
        while (!v_rsp_valid && n < 20) begin
            if (v_rd_en) begin
                rd++;
                maddr = v_addr;
            end
            @(negedge clk);
            n++;
        end
        chk("latency", n, exp_lat);
        chk("rd_en_pulses", rd, exp_err ? 32'd0 : 32'd1);
        if (!exp_err) chk("mem_addr", {24'b0, maddr}, {24'b0, exp_addr});
        chk("rsp_data", v_rsp_data, exp_data);
        chk("rsp_err", {31'b0, v_rsp_err}, {31'b0, exp_err});
        if (rsp_ready) begin
            @(negedge clk);
            chk("rsp_valid_after", {31'b0, v_rsp_valid}, 32'd0);
            chk("req_ready_after", {31'b0, v_req_ready}, 32'd1);
        end
    endtask

    initial begin
        int spurious;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[1] = 32'h8844_22F1;
        mem[2] = 32'h7FA5_8301;
        mem[3] = 32'hCAFE_B00C;
        sel3       = 1'b0;
        req_valid  = 1'b0;
        req_base   = 32'h0;
        req_imm    = 12'h0;
        req_funct3 = 3'b000;
        rsp_ready  = 1'b1;
        rst_n      = 1'b0;

        #1;
        chk("rst_req_ready", {31'b0, req_ready1}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid1}, 32'd0);
        chk("rst_rsp_data", rsp_data1, 32'h0);
        chk("rst_rsp_err", {31'b0, rsp_err1}, 32'd0);
        chk("rst_rd_en", {31'b0, mem_rd_en1}, 32'd0);
        chk("rst_mem_addr", {24'b0, mem_addr1}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_load(1'b0, 32'h4, 12'h000, 3'b000, 32'hFFFF_FFF1, 1'b0, 3, 8'd1);
        run_load(1'b0, 32'h4, 12'h003, 3'b100, 32'h0000_0088, 1'b0, 3, 8'd1);
        run_load(1'b0, 32'h6, 12'h000, 3'b001, 32'hFFFF_8844, 1'b0, 3, 8'd1);
        run_load(1'b0, 32'h4, 12'h000, 3'b101, 32'h0000_22F1, 1'b0, 3, 8'd1);
        run_load(1'b0, 32'h8, 12'hFFC, 3'b010, 32'h8844_22F1, 1'b0, 3, 8'd1);

        run_load(1'b0, 32'h5, 12'h000, 3'b001, 32'h0, 1'b1, 1, 8'd0);
        run_load(1'b0, 32'h6, 12'h000, 3'b010, 32'h0, 1'b1, 1, 8'd0);
        run_load(1'b0, 32'h4, 12'h000, 3'b011, 32'h0, 1'b1, 1, 8'd0);
        chk("err_addr_held", {24'b0, mem_addr1}, 32'd1);

        rsp_ready = 1'b0;
        run_load(1'b0, 32'h9, 12'h000, 3'b000, 32'hFFFF_FF83, 1'b0, 3, 8'd2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_rsp_valid", {31'b0, rsp_valid1}, 32'd1);
            chk("stall_rsp_data", rsp_data1, 32'hFFFF_FF83);
            chk("stall_req_ready", {31'b0, req_ready1}, 32'd0);
        end
        rsp_ready = 1'b1;
        run_load(1'b0, 32'hA, 12'h000, 3'b001, 32'h0000_7FA5, 1'b0, 3, 8'd2);

        run_load(1'b1, 32'hC, 12'h000, 3'b010, 32'hCAFE_B00C, 1'b0, 5, 8'd3);

        @(negedge clk);
        sel3       = 1'b1;
        req_valid  = 1'b1;
        req_base   = 32'hE;
        req_imm    = 12'h000;
        req_funct3 = 3'b101;
        @(negedge clk);
        req_valid = 1'b0;
        chk("lat3_read", {31'b0, mem_rd_en3}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("wait_rst_rsp_valid", {31'b0, rsp_valid3}, 32'd0);
        chk("wait_rst_rsp_data", rsp_data3, 32'h0);
        chk("wait_rst_rsp_err", {31'b0, rsp_err3}, 32'd0);
        chk("wait_rst_rd_en", {31'b0, mem_rd_en3}, 32'd0);
        chk("wait_rst_mem_addr", {24'b0, mem_addr3}, 32'd0);
        chk("wait_rst_req_ready", {31'b0, req_ready3}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid3) spurious++;
        end
        chk("no_spurious_rsp", spurious, 32'd0);
        chk("post_rst_req_ready", {31'b0, req_ready3}, 32'd1);

        run_load(1'b1, 32'hC, 12'h003, 3'b000, 32'hFFFF_FFCA, 1'b0, 5, 8'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
